// File: rtl/data_memory_ctrl.sv
// Data-memory controller for the MEM stage: byte-lane RAM writes, extended
// byte/half/word loads, alignment/range checking and a fixed-latency response pipe.
module data_memory_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 32768,
    parameter int READ_LAT = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              distinct,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH);

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [1:0] size;
        logic       sext;
        logic [1:0] off;
        logic       err;
    } stage_t;

    generate
        if (DATA_W != 32 || READ_LAT < 1 || READ_LAT > 3 || DEPTH * 4 > 2 ** ADDR_W) begin : g_bad_cfg
            $error("data_memory_ctrl: unsupported parameter set");
        end
    endgenerate

    logic              acc, is_load, is_store;
    logic              align_err, range_err, word_oor, err;
    logic [1:0]        off;
    logic [IDX_W-1:0]  word_idx;
    logic [3:0]        be;
    logic [DATA_W-1:0] wr_lanes;
    stage_t            new_stg;
    stage_t            stg      [READ_LAT];
    logic [DATA_W-1:0] stg_data [READ_LAT];
    logic [DATA_W-1:0] mem      [DEPTH];

    // A simultaneous read and write request is treated as a load only.
    assign acc      = distinct & (MemRead | MemWrite);
    assign is_load  = MemRead;
    assign is_store = MemWrite & ~MemRead;
    assign off      = address[1:0];
    assign word_idx = address[ADDR_W-1:2];

    generate
        if (DEPTH * 4 < 2 ** ADDR_W) begin : g_partial_map
            assign word_oor = (32'(word_idx) >= 32'(DEPTH));
        end else begin : g_full_map
            assign word_oor = 1'b0;
        end
    endgenerate

    assign range_err = (|address[31:ADDR_W]) | word_oor;
    assign err       = align_err | range_err;

    always_comb begin
        align_err = 1'b0;
        be        = 4'b0000;
        wr_lanes  = write_data;
        case (size)
            2'b00: begin
                be       = 4'b0001 << off;
                wr_lanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                align_err = off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wr_lanes  = {2{write_data[15:0]}};
            end
            2'b10: begin
                align_err = |off;
                be        = 4'b1111;
            end
            default: align_err = 1'b1;
        endcase
    end

    // RAM and load-data pipe carry no reset; the valid bits gate everything downstream.
    always_ff @(posedge CLK) begin
        if (acc && is_store && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[word_idx[MEM_AW-1:0]][8*k +: 8] <= wr_lanes[8*k +: 8];
            end
        end
        if (acc && is_load && !err) stg_data[0] <= mem[word_idx[MEM_AW-1:0]];
        for (int i = 1; i < READ_LAT; i++) stg_data[i] <= stg_data[i-1];
    end

    always_comb begin
        new_stg         = '0;
        new_stg.valid   = acc;
        new_stg.is_load = is_load;
        new_stg.size    = size;
        new_stg.sext    = sign_ext;
        new_stg.off     = off;
        new_stg.err     = err;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LAT; i++) stg[i] <= '0;
        end else begin
            stg[0] <= new_stg;
            for (int i = 1; i < READ_LAT; i++) stg[i] <= stg[i-1];
        end
    end

    stage_t            last;
    logic [DATA_W-1:0] raw, shifted, ext;

    assign last    = stg[READ_LAT-1];
    assign raw     = stg_data[READ_LAT-1];
    assign shifted = raw >> {last.off, 3'b000};

    always_comb begin
        ext = raw;
        case (last.size)
            2'b00:   ext = {{24{last.sext & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{last.sext & shifted[15]}}, shifted[15:0]};
            default: ext = raw;
        endcase
    end

    assign read_data = (last.valid & last.is_load & ~last.err) ? ext : '0;
    assign rsp_valid = last.valid;
    assign rsp_err   = last.valid & last.err;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < READ_LAT; i++) busy = busy | stg[i].valid;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a READ_LAT=1 instance for the functional path and a READ_LAT=3
// instance for pipelining and asynchronous reset, both fed the same requests.
module tb_data_memory_ctrl;

    logic        CLK = 1'b0;
    logic        reset1, reset3;
    logic        distinct, MemRead, MemWrite, sign_ext;
    logic [1:0]  size;
    logic [31:0] address, write_data;
    logic [31:0] rd1, rd3;
    logic        v1, e1, b1, v3, e3, b3;

    int n_checks = 0;
    int n_errors = 0;
    int n_seen;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.READ_LAT(1)) dut1 (
        .CLK(CLK), .reset(reset1), .distinct(distinct), .MemRead(MemRead),
        .MemWrite(MemWrite), .size(size), .sign_ext(sign_ext), .address(address),
        .write_data(write_data), .read_data(rd1), .rsp_valid(v1), .rsp_err(e1), .busy(b1)
    );

    data_memory_ctrl #(.READ_LAT(3)) dut3 (
        .CLK(CLK), .reset(reset3), .distinct(distinct), .MemRead(MemRead),
        .MemWrite(MemWrite), .size(size), .sign_ext(sign_ext), .address(address),
        .write_data(write_data), .read_data(rd3), .rsp_valid(v3), .rsp_err(e3), .busy(b3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Presents one request for one cycle; returns 1ns after its acceptance edge.
    task automatic req(input logic mr, input logic mw, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd);
        distinct   = 1'b1;
        MemRead    = mr;
        MemWrite   = mw;
        size       = sz;
        sign_ext   = sx;
        address    = a;
        write_data = wd;
        step(1);
        distinct = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic rsp1(input string tag, input logic err, input logic [31:0] data);
        check({tag, "_valid"}, {31'd0, v1}, {31'd0, 1'b1});
        check({tag, "_err"}, {31'd0, e1}, {31'd0, err});
        check({tag, "_data"}, rd1, data);
    endtask

    initial begin
        reset1 = 1'b0; reset3 = 1'b0;
        distinct = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        size = 2'b00; sign_ext = 1'b0; address = '0; write_data = '0;
        #3;
        check("reset_valid1", {31'd0, v1}, 32'd0);
        check("reset_busy1", {31'd0, b1}, 32'd0);
        check("reset_data1", rd1, 32'd0);
        check("reset_valid3", {31'd0, v3}, 32'd0);
        #9;
        reset1 = 1'b1; reset3 = 1'b1;
        step(1);

        // word store then load next cycle
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        rsp1("st_word", 1'b0, 32'h0);
        check("busy_inflight", {31'd0, b1}, 32'd1);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rsp1("ld_word", 1'b0, 32'hDEADBEEF);

        // byte store into lane 1, then extended loads
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h00000080);
        rsp1("st_byte", 1'b0, 32'h0);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
        rsp1("ld_byte_sx", 1'b0, 32'hFFFFFF80);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
        rsp1("ld_byte_zx", 1'b0, 32'h00000080);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        rsp1("ld_half_zx", 1'b0, 32'h000080EF);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
        rsp1("ld_half_sx", 1'b0, 32'hFFFF80EF);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rsp1("ld_word2", 1'b0, 32'hDEAD80EF);

        // error cases
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h00001234);
        rsp1("st_half_mis", 1'b1, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rsp1("ld_after_err", 1'b0, 32'hDEAD80EF);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h00020000, 32'h0);
        rsp1("ld_range", 1'b1, 32'h0);
        req(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        rsp1("ld_size11", 1'b1, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        rsp1("ld_word_mis", 1'b1, 32'h0);

        // read+write together is a load with no write
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
        rsp1("rw_conflict", 1'b0, 32'hDEAD80EF);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rsp1("ld_no_write", 1'b0, 32'hDEAD80EF);

        // upper half store, sign-extended half load
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000CAFE);
        rsp1("st_half_hi", 1'b0, 32'h0);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        rsp1("ld_half_hi", 1'b0, 32'hFFFFCAFE);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rsp1("ld_word3", 1'b0, 32'hCAFE80EF);

        // chip select low: nothing accepted
        distinct = 1'b0; MemRead = 1'b1; size = 2'b10; address = 32'h100;
        step(1);
        check("nosel_valid", {31'd0, v1}, 32'd0);
        check("nosel_busy", {31'd0, b1}, 32'd0);
        MemRead = 1'b0;

        // READ_LAT=3: preload four words, then four back-to-back loads
        for (int i = 0; i < 4; i++)
            req(1'b0, 1'b1, 2'b10, 1'b0, 32'h200 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
        step(4);
        check("lat3_idle_busy", {31'd0, b3}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) req(1'b1, 1'b0, 2'b10, 1'b0, 32'h200 + 32'(4 * c), 32'h0);
            else step(1);
            if (c == 0) check("lat3_busy", {31'd0, b3}, 32'd1);
            if (c >= 2 && c <= 5) begin
                check($sformatf("lat3_valid%0d", c), {31'd0, v3}, 32'd1);
                check($sformatf("lat3_data%0d", c), rd3, 32'h11111111 * 32'(c - 1));
            end else begin
                check($sformatf("lat3_idle%0d", c), {31'd0, v3}, 32'd0);
            end
        end

        // async reset with loads in flight
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h208, 32'h0);
        check("pre_rst_valid", {31'd0, v3}, 32'd1);
        check("pre_rst_data", rd3, 32'h11111111);
        #2;
        reset3 = 1'b0;
        #1;
        check("rst_valid", {31'd0, v3}, 32'd0);
        check("rst_busy", {31'd0, b3}, 32'd0);
        check("rst_data", rd3, 32'h0);
        step(1);
        reset3 = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (v3) n_seen++;
        end
        check("dropped_rsp", 32'(n_seen), 32'd0);

        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step(1);
        check("post_rst_data1", rd3, 32'h22222222);
        step(1);
        check("post_rst_data2", rd3, 32'hCAFE80EF);
        check("post_rst_err", {31'd0, e3}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
